// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared common-data-bus lane types, constants and helpers
package cdb_arbiter_pkg;
    typedef logic [31:0] memory_word_t;
    typedef struct packed {
        logic [31:0]  tag;
        memory_word_t value;
        logic         regwr;
    } cdb_lane_t;
    localparam int CDB_LANES = 2;
    localparam logic [31:0] CDB_IDLE_TAG = 32'd0;
    localparam cdb_lane_t CDB_IDLE = '{tag: CDB_IDLE_TAG, value: 32'd0, regwr: 1'b0};
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction
endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// rr_pick2: combinational round-robin picker granting up to two requesters
import cdb_arbiter_pkg::*;
module rr_pick2 #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant1,
    output logic [NUM_REQ-1:0] grant2,
    output logic [PTR_W-1:0]   idx1,
    output logic [PTR_W-1:0]   idx2,
    output logic               valid1,
    output logic               valid2
);
    logic [PTR_W-1:0] order [NUM_REQ];
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_order
        assign order[k] = PTR_W'((int'(ptr) + k) % NUM_REQ);
    end
    // scan from ptr with wrap; first eligible takes lane 1, second lane 2
    always_comb begin
        valid1 = 1'b0;
        valid2 = 1'b0;
        idx1 = '0;
        idx2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (elig[order[i]]) begin
                if (!valid1) begin
                    valid1 = 1'b1;
                    idx1 = order[i];
                end else if (!valid2) begin
                    valid2 = 1'b1;
                    idx2 = order[i];
                end
            end
        end
    end
    assign grant1 = valid1 ? NUM_REQ'(1) << idx1 : '0;
    assign grant2 = valid2 ? NUM_REQ'(1) << idx2 : '0;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the two CDB broadcast lanes among completing units
import cdb_arbiter_pkg::*;
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_tag,
    input  logic [NUM_REQ*32-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_regwr,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [31:0]           cdb_tag1,
    output logic [31:0]           cdb_tag2,
    output logic [31:0]           cdb_value1,
    output logic [31:0]           cdb_value2,
    output logic                  cdb_regwr1,
    output logic                  cdb_regwr2
);
    logic [NUM_REQ-1:0] elig, grant1, grant2;
    logic [PTR_W-1:0]   rr_ptr, idx1, idx2;
    logic               valid1, valid2;
    cdb_lane_t          lane_d [CDB_LANES];
    cdb_lane_t          lane_q [CDB_LANES];
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_elig
        assign elig[r] = req_valid[r] && req_tag[r*32 +: 32] != CDB_IDLE_TAG;
    end
    rr_pick2 #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .elig   (elig),
        .ptr    (rr_ptr),
        .grant1 (grant1),
        .grant2 (grant2),
        .idx1   (idx1),
        .idx2   (idx2),
        .valid1 (valid1),
        .valid2 (valid2)
    );
    assign req_ready = (reset || flush) ? '0 : (grant1 | grant2);
    assign lane_d[0] = valid1 ? cdb_lane_t'{tag: req_tag[int'(idx1)*32 +: 32],
                                            value: req_data[int'(idx1)*32 +: 32],
                                            regwr: req_regwr[idx1]} : CDB_IDLE;
    assign lane_d[1] = valid2 ? cdb_lane_t'{tag: req_tag[int'(idx2)*32 +: 32],
                                            value: req_data[int'(idx2)*32 +: 32],
                                            regwr: req_regwr[idx2]} : CDB_IDLE;
    // register granted completions onto the lanes; flush/reset load idle
    always_ff @(posedge clk) begin
        lane_q[0] <= (reset || flush) ? CDB_IDLE : lane_d[0];
        lane_q[1] <= (reset || flush) ? CDB_IDLE : lane_d[1];
    end
    // advance the pointer past the last granted requester
    always_ff @(posedge clk) begin
        if (reset)
            rr_ptr <= '0;
        else if (!flush)
            rr_ptr <= valid2 ? PTR_W'(wrap_inc(int'(idx2), NUM_REQ)) :
                      valid1 ? PTR_W'(wrap_inc(int'(idx1), NUM_REQ)) : rr_ptr;
    end
    assign cdb_tag1   = lane_q[0].tag;
    assign cdb_value1 = lane_q[0].value;
    assign cdb_regwr1 = lane_q[0].regwr;
    assign cdb_tag2   = lane_q[1].tag;
    assign cdb_value2 = lane_q[1].value;
    assign cdb_regwr2 = lane_q[1].regwr;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of the CDB arbiter
module tb_cdb_arbiter;
    localparam int N = 4;
    logic           clk = 1'b0;
    logic           reset, flush;
    logic [N-1:0]   req_valid, req_regwr, req_ready;
    logic [31:0]    tag_a [N];
    logic [31:0]    data_a [N];
    logic [N*32-1:0] req_tag, req_data;
    logic [31:0]    cdb_tag1, cdb_tag2, cdb_value1, cdb_value2;
    logic           cdb_regwr1, cdb_regwr2;
    int             checks = 0;
    int             fails = 0;
    int             m_ptr, nx_ptr;
    logic [N-1:0]   exp_ready;
    logic [31:0]    nx_t1, nx_t2, nx_v1, nx_v2;
    logic           nx_r1, nx_r2;

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .req_data   (req_data),
        .req_regwr  (req_regwr),
        .req_ready  (req_ready),
        .cdb_tag1   (cdb_tag1),
        .cdb_tag2   (cdb_tag2),
        .cdb_value1 (cdb_value1),
        .cdb_value2 (cdb_value2),
        .cdb_regwr1 (cdb_regwr1),
        .cdb_regwr2 (cdb_regwr2)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_tag = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_tag[i*32 +: 32] = tag_a[i];
            req_data[i*32 +: 32] = data_a[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_valid = '0;
        req_regwr = '0;
        flush = 1'b0;
        for (int i = 0; i < N; i++) begin
            tag_a[i] = 32'd0;
            data_a[i] = 32'd0;
        end
    endtask

    // reference: scan from the pointer, first two eligible requesters win
    task automatic model_eval();
        int n;
        int i;
        n = 0;
        exp_ready = '0;
        {nx_t1, nx_v1, nx_r1} = '0;
        {nx_t2, nx_v2, nx_r2} = '0;
        nx_ptr = reset ? 0 : m_ptr;
        if (!reset && !flush) begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (req_valid[i] && tag_a[i] != 0 && n < 2) begin
                    exp_ready[i] = 1'b1;
                    if (n == 0) {nx_t1, nx_v1, nx_r1} = {tag_a[i], data_a[i], req_regwr[i]};
                    else {nx_t2, nx_v2, nx_r2} = {tag_a[i], data_a[i], req_regwr[i]};
                    nx_ptr = (i + 1) % N;
                    n++;
                end
            end
        end
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) tag_a[i] = 32'(i + 1);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        tick();
        checks++;
        if ({cdb_tag1, cdb_tag2, cdb_value1, cdb_value2, cdb_regwr1, cdb_regwr2} !== 130'd0) begin
            fails++; $display("FAIL reset_lanes: got tags %h %h values %h %h want all 0", cdb_tag1, cdb_tag2, cdb_value1, cdb_value2);
        end
        reset = 1'b0;
        set_idle();
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL idle_ready: got %b want 0000", req_ready); end
        tick();
        tick();
        checks++;
        if ({cdb_tag1, cdb_tag2} !== 64'd0) begin fails++; $display("FAIL idle_lanes: got %h %h want 0 0", cdb_tag1, cdb_tag2); end
    endtask

    task automatic test_single();
        set_idle();
        req_valid[2] = 1'b1;
        tag_a[2] = 32'd5;
        data_a[2] = 32'hAB;
        req_regwr[2] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        set_idle();
        checks++;
        if ({cdb_tag1, cdb_value1, cdb_regwr1, cdb_tag2} !== {32'd5, 32'hAB, 1'b1, 32'd0}) begin
            fails++; $display("FAIL single_lanes: got tag1=%0d val1=%h rw1=%b tag2=%0d want 5 ab 1 0", cdb_tag1, cdb_value1, cdb_regwr1, cdb_tag2);
        end
    endtask

    task automatic test_wrap();
        set_idle();
        req_valid = 4'b1001;
        tag_a[3] = 32'h33;
        data_a[3] = 32'h333;
        tag_a[0] = 32'h30;
        data_a[0] = 32'h300;
        req_regwr = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b1001) begin fails++; $display("FAIL wrap_ready: got %b want 1001", req_ready); end
        tick();
        set_idle();
        checks++;
        if ({cdb_tag1, cdb_tag2, cdb_value1, cdb_value2, cdb_regwr1, cdb_regwr2} !== {32'h33, 32'h30, 32'h333, 32'h300, 2'b01}) begin
            fails++; $display("FAIL wrap_lanes: got %h %h %h %h %b%b want 33 30 333 300 01", cdb_tag1, cdb_tag2, cdb_value1, cdb_value2, cdb_regwr1, cdb_regwr2);
        end
    endtask

    task automatic test_all_four();
        set_idle();
        req_valid[3] = 1'b1;
        tag_a[3] = 32'h3F;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin fails++; $display("FAIL park_ready: got %b want 1000", req_ready); end
        tick();
        req_valid = 4'b1111;
        req_regwr = 4'b0101;
        for (int i = 0; i < N; i++) begin
            tag_a[i] = 32'(i + 1);
            data_a[i] = 32'h100 + 32'(i);
        end
        #1;
        checks++;
        if (req_ready !== 4'b0011) begin fails++; $display("FAIL all4_c0_ready: got %b want 0011", req_ready); end
        tick();
        checks++;
        if (req_ready !== 4'b1100) begin fails++; $display("FAIL all4_c1_ready: got %b want 1100", req_ready); end
        checks++;
        if ({cdb_tag1, cdb_tag2, cdb_value1, cdb_value2, cdb_regwr1, cdb_regwr2} !== {32'd1, 32'd2, 32'h100, 32'h101, 2'b10}) begin
            fails++; $display("FAIL all4_c1_lanes: got %h %h %h %h %b%b want 1 2 100 101 10", cdb_tag1, cdb_tag2, cdb_value1, cdb_value2, cdb_regwr1, cdb_regwr2);
        end
        tick();
        checks++;
        if (req_ready !== 4'b0011) begin fails++; $display("FAIL all4_c2_ready: got %b want 0011", req_ready); end
        checks++;
        if ({cdb_tag1, cdb_tag2, cdb_regwr1, cdb_regwr2} !== {32'd3, 32'd4, 2'b10}) begin
            fails++; $display("FAIL all4_c2_lanes: got %h %h %b%b want 3 4 10", cdb_tag1, cdb_tag2, cdb_regwr1, cdb_regwr2);
        end
        tick();
        set_idle();
        checks++;
        if ({cdb_tag1, cdb_tag2} !== {32'd1, 32'd2}) begin fails++; $display("FAIL all4_c3_lanes: got %h %h want 1 2", cdb_tag1, cdb_tag2); end
    endtask

    task automatic test_tag_zero();
        set_idle();
        req_valid = 4'b1010;
        tag_a[1] = 32'd0;
        data_a[1] = 32'h11;
        tag_a[3] = 32'd7;
        data_a[3] = 32'h77;
        req_regwr = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin fails++; $display("FAIL tag0_ready: got %b want 1000", req_ready); end
        tick();
        set_idle();
        checks++;
        if ({cdb_tag1, cdb_value1, cdb_regwr1, cdb_tag2, cdb_value2, cdb_regwr2} !== {32'd7, 32'h77, 1'b1, 32'd0, 32'd0, 1'b0}) begin
            fails++; $display("FAIL tag0_lanes: got %h %h %b %h %h %b want 7 77 1 0 0 0", cdb_tag1, cdb_value1, cdb_regwr1, cdb_tag2, cdb_value2, cdb_regwr2);
        end
    endtask

    task automatic test_flush();
        set_idle();
        flush = 1'b1;
        req_valid = 4'b1011;
        tag_a[0] = 32'd8;
        tag_a[1] = 32'd9;
        tag_a[3] = 32'd10;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL flush_ready: got %b want 0000", req_ready); end
        checks++;
        if (cdb_tag1 !== 32'd7) begin fails++; $display("FAIL flush_no_retract: got %h want 7", cdb_tag1); end
        tick();
        flush = 1'b0;
        checks++;
        if ({cdb_tag1, cdb_tag2} !== 64'd0) begin fails++; $display("FAIL flush_lanes: got %h %h want 0 0", cdb_tag1, cdb_tag2); end
        #1;
        checks++;
        if (req_ready !== 4'b0011) begin fails++; $display("FAIL flush_ptr_ready: got %b want 0011", req_ready); end
        tick();
        req_valid = 4'b1000;
        checks++;
        if ({cdb_tag1, cdb_tag2} !== {32'd8, 32'd9}) begin fails++; $display("FAIL post_flush_lanes: got %h %h want 8 9", cdb_tag1, cdb_tag2); end
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid();
        set_idle();
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) tag_a[i] = 32'h21 + 32'(i);
        #1;
        checks++;
        if (req_ready !== 4'b0011) begin fails++; $display("FAIL rmid_pre_ready: got %b want 0011", req_ready); end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL rmid_ready: got %b want 0000", req_ready); end
        tick();
        reset = 1'b0;
        checks++;
        if ({cdb_tag1, cdb_tag2} !== 64'd0) begin fails++; $display("FAIL rmid_lanes: got %h %h want 0 0", cdb_tag1, cdb_tag2); end
        #1;
        checks++;
        if (req_ready !== 4'b0011) begin fails++; $display("FAIL rmid_ptr_ready: got %b want 0011", req_ready); end
        tick();
        set_idle();
        checks++;
        if ({cdb_tag1, cdb_tag2} !== {32'h21, 32'h22}) begin fails++; $display("FAIL rmid_post_lanes: got %h %h want 21 22", cdb_tag1, cdb_tag2); end
    endtask

    task automatic test_random();
        set_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_ptr = 0;
        for (int c = 0; c < 300; c++) begin
            req_valid = N'($urandom);
            req_regwr = N'($urandom);
            for (int i = 0; i < N; i++) begin
                tag_a[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 255));
                data_a[i] = $urandom;
            end
            flush = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 49) == 0);
            #1;
            model_eval();
            checks++;
            if (req_ready !== exp_ready) begin fails++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
            tick();
            m_ptr = nx_ptr;
            checks++;
            if ({cdb_tag1, cdb_value1, cdb_regwr1, cdb_tag2, cdb_value2, cdb_regwr2} !== {nx_t1, nx_v1, nx_r1, nx_t2, nx_v2, nx_r2}) begin
                fails++; $display("FAIL rand_lanes c%0d: got %h/%h/%b %h/%h/%b want %h/%h/%b %h/%h/%b", c,
                    cdb_tag1, cdb_value1, cdb_regwr1, cdb_tag2, cdb_value2, cdb_regwr2, nx_t1, nx_v1, nx_r1, nx_t2, nx_v2, nx_r2);
            end
        end
        reset = 1'b0;
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_all_four();
        test_tag_zero();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the two common-data-bus broadcast lanes (cdb_tag1/cdb_value1, cdb_tag2/cdb_value2) among NUM_REQ completing functional units ahead of the commit stage. Each cycle, up to two valid completions are granted in round-robin order. Granted completions are registered onto the CDB lanes, and the ROB/map-table update logic consumes them one cycle later. The arbiter adds one register stage, guarantees starvation freedom and drops everything on flush.

## Interface
Parameters:
- NUM_REQ, 4, number of completion requesters (ALU0, ALU1, MUL, LSU); range 2..8
- PTR_W, $clog2(NUM_REQ), round-robin pointer width

Ports:
- clk  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high; sampled on rising clk
- flush  input  1  branch-mispredict squash; synchronous
- req_valid  input  NUM_REQ  completion pending per requester
- req_tag  input  NUM_REQ x int  ROB tag of completion; tag 0 = no instruction
- req_data  input  NUM_REQ x MemoryWord  result value
- req_regwr  input  NUM_REQ  ctrl_bits.regwr of the completing instruction
- req_ready  output  NUM_REQ  grant; transfer occurs when req_valid & req_ready
- cdb_tag1, cdb_tag2  output  int  broadcast tag per lane; 0 = lane idle
- cdb_value1, cdb_value2  output  MemoryWord  broadcast value per lane
- cdb_regwr1, cdb_regwr2  output  1  broadcast carries a register write

## Operation
- Eligible requester i: req_valid[i]=1 and req_tag[i]!=0. A valid request with tag 0 is ignored: never granted, req_ready[i]=0.
- Scan order starts at rr_ptr and wraps modulo NUM_REQ. The first eligible requester gets lane 1. The second eligible requester gets lane 2. At most two grants per cycle.
- req_ready is combinational from the current eligibility and rr_ptr. Requesters hold valid/tag/data stable until granted.
- Pointer update:
  - Two grants: rr_ptr ← (second granted index + 1) mod NUM_REQ.
  - One grant: rr_ptr ← (that index + 1) mod NUM_REQ.
  - No grant: rr_ptr unchanged.
- Lane 2 is never used without lane 1. A single grant always goes on lane 1.
- Ungranted lane registers load tag 0, value 0, regwr 0.
- flush=1: all req_ready=0 that cycle. Lane registers load idle at the next edge. rr_ptr is unchanged.
- reset=1: same effect as flush, and rr_ptr ← 0. Reset has priority over flush.

## Timing
- Reset values: cdb_tag1/2=0, cdb_value1/2=0, cdb_regwr1/2=0, rr_ptr=0. req_ready is all 0 during reset.
- Latency: a grant in cycle N appears on the CDB lanes in cycle N+1, held for exactly one cycle.
- Throughput: 2 completions/cycle sustained.
- Fairness: a continuously eligible requester is granted within ceil(NUM_REQ/2) cycles. With NUM_REQ=4, all four continuously valid, each is granted every 2nd cycle.
- A requester may deassert valid without being granted; no grant is recorded.
- Flush in cycle N: no grant in N; CDB lanes idle in N+1. Lanes already driven in N are not retracted.
- Reset asserted mid-stream: same-cycle grants suppressed; outputs idle from the next edge.

## Structure
- Shared package additions:
  - cdb_lane_t struct {int tag; MemoryWord value; logic regwr;}
  - CDB_LANES = 2
  - CDB_IDLE_TAG = 0
- Lane registers are two cdb_lane_t flops; outputs are unpacked from them.
- Sub-module rr_pick2:
  - Combinational; NUM_REQ-bit eligibility vector + rr_ptr in.
  - Out: grant1/grant2 one-hot vectors, their indices, and valid bits.
  - Reused by the issue-port arbiter.

## Test plan
- Reset, then no requests → all cdb tags 0, req_ready=0000, rr_ptr stays 0.
- Single request: req 2 valid, tag 5, data 0xAB, regwr 1 → req_ready=0100 same cycle; next cycle cdb_tag1=5, cdb_value1=0xAB, cdb_regwr1=1, cdb_tag2=0; rr_ptr=3.
- All four valid, tags 1..4, held valid after grants:
  - Cycle 0 grants 0,1.
  - Cycle 1 grants 2,3; CDB shows (1,2).
  - Cycle 2 grants 0,1; CDB shows (3,4).
  - Confirms wrap-around and fairness.
- rr_ptr=3, requests 3 and 0 valid → lane1=req 3, lane2=req 0; rr_ptr becomes 1.
- req 1 valid with tag 0, req 3 valid tag 7 → only req 3 granted, on lane 1; req_ready[1]=0.
- Flush with reqs 0,1 valid (tags 8,9) → req_ready=0000; next cycle both lanes idle. rr_ptr unchanged; requests granted the cycle after flush deasserts.
